// File: rtl/vga_sync_ctrl_pkg.sv
// Shared VGA 640x480@60 raster timing constants, run/stop state encodings
// and a small window-decode helper. Used by the sync controller, the
// pixel generator and the benches.
package vga_sync_ctrl_pkg;

  // Horizontal timing, in pixels
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing, in lines
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;
  localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Asserted sync level (0 = active-low)
  localparam logic VGA_SYNC_POL = 1'b0;

  // Run/stop sequencer state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // 1 when pos lies in the inclusive window [lo, hi]
  function automatic logic in_span(input logic [9:0] pos,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_ctrl_axis.sv
// vga_axis_counter: modulo-TOTAL counter for one raster axis.
//  clk, rst : clock, asynchronous active-high reset
//  clr      : synchronous clear to 0 (dominates inc)
//  inc      : advance by one; wraps TOTAL-1 -> 0
//  cnt      : current position
//  tc       : terminal count, 1 when inc=1 and cnt=TOTAL-1 (wrap happens on this edge)
module vga_axis_counter #(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

  assign tc = inc & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: VGA raster timing sequencer with clean run/stop at frame boundaries.
//  clk         : 100 MHz system clock
//  rst         : asynchronous reset, active-high
//  pix_en      : pixel-rate enable (one clk wide)
//  run         : level request to scan out frames
//  busy        : 1 while in RUN
//  hsync/vsync : sync outputs, asserted level SYNC_POL
//  video_on    : visible-area qualifier
//  x, y        : pixel coordinates, 0 outside the visible area
//  line_start  : 1-clk pulse when h enters 0
//  frame_start : 1-clk pulse when (h,v) enters (0,0)
module vga_sync_ctrl
  import vga_sync_ctrl_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter logic        SYNC_POL  = VGA_SYNC_POL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       run,
  output logic       busy,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_sync_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [0:0] state;
  logic       stop_req;
  logic       stop_nxt;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       h_tc, v_tc;
  logic       h_inc;
  logic       start, go_idle, nxt_vis;

  assign busy  = (state == ST_RUN);
  assign h_inc = pix_en & busy;

  vga_axis_counter #(.TOTAL(H_TOTAL), .WIDTH(10)) u_h_cnt (
    .clk (clk),
    .rst (rst),
    .clr (~busy),
    .inc (h_inc),
    .cnt (h_cnt),
    .tc  (h_tc)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .WIDTH(10)) u_v_cnt (
    .clk (clk),
    .rst (rst),
    .clr (~busy),
    .inc (h_tc),
    .cnt (v_cnt),
    .tc  (v_tc)
  );

  // Outputs are decoded from the position the counters load on this edge,
  // so syncs and coordinates carry no skew relative to each other.
  always_comb begin
    stop_nxt = stop_req;
    if (busy) stop_nxt = ~run;
    else      stop_nxt = 1'b0;

    start   = ~busy & pix_en & run;
    // v_tc already implies the frame-wrap pixel edge; the stop decision
    // includes this cycle's run sample.
    go_idle = v_tc & stop_nxt;

    h_nxt = '0;
    v_nxt = '0;
    if (busy) begin
      h_nxt = h_tc ? '0 : h_cnt + 10'd1;
      if (v_tc)      v_nxt = '0;
      else if (h_tc) v_nxt = v_cnt + 10'd1;
      else           v_nxt = v_cnt;
    end
    nxt_vis = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      stop_req <= 1'b0;
    end else begin
      stop_req <= stop_nxt;
      if (start)        state <= ST_RUN;
      else if (go_idle) state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (start || (busy && !go_idle)) begin
          hsync       <= in_span(h_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
          vsync       <= in_span(v_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
          video_on    <= nxt_vis;
          x           <= nxt_vis ? h_nxt : '0;
          y           <= nxt_vis ? v_nxt : '0;
          line_start  <= (h_nxt == '0);
          frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end else begin
          hsync    <= ~SYNC_POL;
          vsync    <= ~SYNC_POL;
          video_on <= 1'b0;
          x        <= '0;
          y        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Self-checking bench for vga_sync_ctrl using a reduced raster
// (25 x 17 pixels) so whole frames fit in a short run.
module tb_vga_sync_ctrl;

  localparam int HV = 16, HF = 2, HSW = 4, HB = 3;
  localparam int VV = 10, VF = 2, VSW = 2, VB = 3;
  localparam int HT = 25, VT = 17, FRAME = 425;
  localparam int HS0 = 18, VS0 = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  logic run = 1'b0;
  logic busy, hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] x, y;

  vga_sync_ctrl #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .run(run), .busy(busy),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raster position as a linear pixel index within the frame.
  bit m_run = 1'b0;
  int m_p = 0;
  bit m_ls = 1'b0, m_fs = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_p = 0; m_ls = 1'b0; m_fs = 1'b0;
    end else begin
      m_ls = 1'b0; m_fs = 1'b0;
      if (pix_en) begin
        if (!m_run) begin
          if (run) begin
            m_run = 1'b1; m_p = 0; m_ls = 1'b1; m_fs = 1'b1;
          end
        end else if (m_p == FRAME - 1) begin
          m_p = 0;
          if (!run) m_run = 1'b0;
          else begin m_ls = 1'b1; m_fs = 1'b1; end
        end else begin
          m_p = m_p + 1;
          if (m_p % HT == 0) m_ls = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int h, v;
    bit e_vo;
    h = m_p % HT;
    v = m_p / HT;
    e_vo = m_run && h < HV && v < VV;
    chk("busy", busy, m_run);
    chk("hsync", hsync, !(m_run && h >= HS0 && h < HS0 + HSW));
    chk("vsync", vsync, !(m_run && v >= VS0 && v < VS0 + VSW));
    chk("video_on", video_on, e_vo);
    chk("x", x, e_vo ? h : 0);
    chk("y", y, e_vo ? v : 0);
    chk("line_start", line_start, m_ls);
    chk("frame_start", frame_start, m_fs);
  end

  // Outputs captured just after the pixel edge (pulses still visible).
  logic s_hs, s_vs, s_vo, s_ls, s_fs, s_busy;
  logic [9:0] s_x, s_y;

  task automatic pix(input int gap);
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    s_hs = hsync; s_vs = vsync; s_vo = video_on; s_ls = line_start;
    s_fs = frame_start; s_busy = busy; s_x = x; s_y = y;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  initial begin
    int period, first_hs, hs_cnt0, first_vo_off, first_vs, vs_cnt, ls_cnt, first_ls;
    int steps, fs_seen, busy_drop;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_hsync", hsync, 1);
    chk("reset_vsync", vsync, 1);
    chk("reset_video_on", video_on, 0);
    chk("reset_xy", {x, y}, 0);
    chk("reset_pulses", {line_start, frame_start}, 0);

    repeat (500) pix(4);
    chk("idle_busy", busy, 0);
    chk("idle_syncs", {hsync, vsync}, 2'b11);

    // Start of scan-out
    run = 1'b1;
    pix(4);
    chk("start_busy", s_busy, 1);
    chk("start_fs", s_fs, 1);
    chk("start_ls", s_ls, 1);
    chk("start_xy", {s_x, s_y}, 0);
    chk("start_video_on", s_vo, 1);

    period = -1; first_hs = -1; hs_cnt0 = 0; first_vo_off = -1;
    first_vs = -1; vs_cnt = 0; ls_cnt = 0; first_ls = -1;
    for (int n = 1; n <= 1000; n++) begin
      pix(4);
      if (s_fs) begin period = n; break; end
      if (!s_hs && first_hs < 0) first_hs = n;
      if (!s_hs && n < HT) hs_cnt0++;
      if (!s_vo && first_vo_off < 0) first_vo_off = n;
      if (!s_vs) begin if (first_vs < 0) first_vs = n; vs_cnt++; end
      if (s_ls) begin ls_cnt++; if (first_ls < 0) first_ls = n; end
    end
    chk("frame_period", period, 425);
    chk("wrap_ls", s_ls, 1);
    chk("hsync_first_low", first_hs, 18);
    chk("hsync_low_width", hs_cnt0, 4);
    chk("video_off_h", first_vo_off, 16);
    chk("vsync_first_low", first_vs, 300);
    chk("vsync_low_pixels", vs_cnt, 50);
    chk("line_starts", ls_cnt, 16);
    chk("line_period", first_ls, 25);

    // Drop run at line 5: frame completes, then idle with no frame_start
    repeat (125) pix(4);
    run = 1'b0;
    steps = 0; fs_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      pix(4);
      steps++;
      if (s_fs) fs_seen++;
      if (!s_busy) break;
    end
    chk("stop_steps", steps, 300);
    repeat (50) begin pix(4); if (s_fs) fs_seen++; end
    chk("stop_no_fs", fs_seen, 0);
    chk("stop_busy", busy, 0);

    // Drop at line 5, re-raise at line 10: uninterrupted
    run = 1'b1;
    pix(4);
    chk("restart_fs", s_fs, 1);
    repeat (125) pix(4);
    run = 1'b0;
    busy_drop = 0;
    repeat (125) begin pix(4); if (!s_busy) busy_drop++; end
    run = 1'b1;
    steps = 0;
    for (int k = 0; k < 1000; k++) begin
      pix(4);
      steps++;
      if (!s_busy) busy_drop++;
      if (s_fs) break;
    end
    chk("cancel_steps", steps, 175);
    chk("cancel_busy_drop", busy_drop, 0);

    // run falls on the very frame-wrap edge
    repeat (FRAME - 1) pix(4);
    run = 1'b0;
    pix(4);
    chk("edge_stop_busy", s_busy, 0);
    chk("edge_stop_fs", s_fs, 0);
    repeat (10) pix(4);

    // Irregular pix_en spacing
    run = 1'b1;
    pix($urandom_range(1, 9));
    chk("irr_start_fs", s_fs, 1);
    period = -1; first_hs = -1;
    for (int n = 1; n <= 1000; n++) begin
      pix($urandom_range(1, 9));
      if (s_fs) begin period = n; break; end
      if (!s_hs && first_hs < 0) first_hs = n;
    end
    chk("irr_frame_period", period, 425);
    chk("irr_hsync_first_low", first_hs, 18);

    // Async reset in the middle of hsync and vsync (h=20, v=13)
    repeat (345) pix(4);
    chk("pre_rst_syncs", {s_hs, s_vs}, 2'b00);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_syncs", {hsync, vsync}, 2'b11);
    chk("async_rst_video", video_on, 0);
    chk("async_rst_xy", {x, y}, 0);
    @(posedge clk); #1 rst = 1'b0;
    pix(4);
    chk("post_rst_fs", s_fs, 1);
    chk("post_rst_xy", {s_x, s_y}, 0);
    chk("post_rst_video", s_vo, 1);
    repeat (40) pix(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
